// File: rtl/miso_word_averager.sv
// ----------------------------------------------------------------------------
// miso_word_averager
// Averages blocks of N = 2^LOG2_SAMPLES unsigned words received from an SPI
// master MISO buffer. Each completed block produces a truncated average and
// the block maximum. A two-state output stage (EMPTY / PENDING) holds the
// result until the consumer takes it.
//
// Output handshake: o_avg_valid high means o_avg/o_max hold a result that has
// not been consumed; the result is consumed on a rising edge where both
// o_avg_valid and i_avg_ready are high (and i_clr is low). While o_avg_valid
// is high o_avg/o_max do not change unless a new result replaces the one
// consumed on that same edge. i_avg_ready is ignored when o_avg_valid is low.
// A result that completes while an unconsumed one is held and not being
// consumed is dropped, and o_overrun is set until i_clr or i_rst.
// ----------------------------------------------------------------------------
module miso_word_averager #(
   parameter int DATA_WIDTH   = 16,
   parameter int LOG2_SAMPLES = 3
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic [DATA_WIDTH-1:0]   i_data,
   input  logic                    i_data_valid,
   input  logic                    i_clr,
   output logic [DATA_WIDTH-1:0]   o_avg,
   output logic                    o_avg_valid,
   input  logic                    i_avg_ready,
   output logic [DATA_WIDTH-1:0]   o_max,
   output logic [LOG2_SAMPLES-1:0] o_sample_cnt,
   output logic                    o_overrun,
   output logic                    o_dbg_state
);

   // Accumulator is wide enough for N full-scale words, so it never wraps.
   localparam int ACC_W = DATA_WIDTH + LOG2_SAMPLES;

   typedef enum logic {
      EMPTY   = 1'b0,
      PENDING = 1'b1
   } state_t;

   state_t                  state;
   logic [ACC_W-1:0]        acc;
   logic [ACC_W-1:0]        acc_sum;
   logic [DATA_WIDTH-1:0]   run_max;
   logic [DATA_WIDTH-1:0]   blk_max;
   logic [DATA_WIDTH-1:0]   blk_avg;
   logic [LOG2_SAMPLES-1:0] sample_cnt;
   logic                    last_sample;
   logic                    block_done;

   // Running sum/max including the current word, and block completion detect.
   always_comb begin
      acc_sum     = acc + {{LOG2_SAMPLES{1'b0}}, i_data};
      blk_max     = (i_data > run_max) ? i_data : run_max;
      blk_avg     = acc_sum[ACC_W-1:LOG2_SAMPLES];
      last_sample = (sample_cnt == {LOG2_SAMPLES{1'b1}});
      block_done  = i_data_valid && !i_clr && last_sample;
   end

   // Block accumulation; the last word of a block restarts the block on the
   // same edge so back-to-back strobes lose nothing.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         acc        <= '0;
         run_max    <= '0;
         sample_cnt <= '0;
      end else if (i_clr) begin
         acc        <= '0;
         run_max    <= '0;
         sample_cnt <= '0;
      end else if (i_data_valid) begin
         if (last_sample) begin
            acc        <= '0;
            run_max    <= '0;
            sample_cnt <= '0;
         end else begin
            acc        <= acc_sum;
            run_max    <= blk_max;
            sample_cnt <= sample_cnt + 1'b1;
         end
      end
   end

   // Output stage: holds one result, replaces it only when consumed on the
   // same edge, otherwise drops the newcomer and flags the overrun.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state       <= EMPTY;
         o_avg_valid <= 1'b0;
         o_avg       <= '0;
         o_max       <= '0;
         o_overrun   <= 1'b0;
      end else if (i_clr) begin
         state       <= EMPTY;
         o_avg_valid <= 1'b0;
         o_avg       <= '0;
         o_max       <= '0;
         o_overrun   <= 1'b0;
      end else begin
         case (state)
            EMPTY: begin
               if (block_done) begin
                  o_avg       <= blk_avg;
                  o_max       <= blk_max;
                  o_avg_valid <= 1'b1;
                  state       <= PENDING;
               end
            end
            PENDING: begin
               if (block_done) begin
                  if (i_avg_ready) begin
                     o_avg <= blk_avg;
                     o_max <= blk_max;
                  end else begin
                     o_overrun <= 1'b1;
                  end
               end else if (i_avg_ready) begin
                  o_avg_valid <= 1'b0;
                  state       <= EMPTY;
               end
            end
            default: begin
               state       <= EMPTY;
               o_avg_valid <= 1'b0;
            end
         endcase
      end
   end

   // Expose internal state for debug and external checkers.
   always_comb begin
      o_sample_cnt = sample_cnt;
      o_dbg_state  = state;
   end

endmodule

// File: doc/miso_word_averager.md
MISO_WORD_AVERAGER -- requirements
Module: miso_word_averager

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, width of received MISO word and of the average result.
REQ-002 SHALL have parameter LOG2_SAMPLES, default 3, block size N = 2^LOG2_SAMPLES words per average.
REQ-003 SHALL have port i_clk  input  1  single system clock; all state on rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port i_data  input  DATA_WIDTH  unsigned word from SPI master miso buffer.
REQ-006 SHALL have port i_data_valid  input  1  one-cycle strobe, i_data is a new word.
REQ-007 SHALL have port i_clr  input  1  synchronous clear of all accumulation state.
REQ-008 SHALL have port o_avg  output  DATA_WIDTH  completed block average.
REQ-009 SHALL have port o_avg_valid  output  1  o_avg holds an unconsumed result.
REQ-010 SHALL have port i_avg_ready  input  1  consumer accepts o_avg this cycle.
REQ-011 SHALL have port o_max  output  DATA_WIDTH  largest word of the block reported in o_avg.
REQ-012 SHALL have port o_sample_cnt  output  LOG2_SAMPLES  words accumulated in current block.
REQ-013 SHALL have port o_overrun  output  1  sticky, a completed result was dropped.

Function
REQ-014 SHALL hold accumulator of DATA_WIDTH+LOG2_SAMPLES bits; no overflow possible, no saturation.
REQ-015 SHALL on i_data_valid with o_sample_cnt < N-1: acc <= acc + i_data, run_max <= max(run_max, i_data), o_sample_cnt +1.
REQ-016 SHALL on i_data_valid with o_sample_cnt == N-1 complete block: result = (acc + i_data) >> LOG2_SAMPLES (truncate), result max = max(run_max, i_data); acc, run_max, o_sample_cnt <= 0 same edge.
REQ-017 SHALL accumulate next block immediately after completion; no dead cycle, back-to-back strobes every cycle accepted.
REQ-018 SHALL implement output FSM with states EMPTY (o_avg_valid=0) and PENDING (o_avg_valid=1).
REQ-019 SHALL in EMPTY on completion load o_avg/o_max, go PENDING; o_avg_valid rises the cycle after final strobe (latency 1).
REQ-020 SHALL in PENDING hold o_avg/o_max stable; i_avg_ready high -> EMPTY next cycle.
REQ-021 SHALL in PENDING with completion and i_avg_ready same cycle load new result, stay PENDING, no overrun.
REQ-022 SHALL in PENDING with completion and i_avg_ready low keep old result, discard new, set o_overrun.
REQ-023 SHALL ignore i_avg_ready in EMPTY.
REQ-024 SHALL on i_clr zero acc, run_max, o_sample_cnt, o_avg, o_max, o_overrun, go EMPTY; i_clr wins over simultaneous i_data_valid (word discarded) and i_avg_ready.
REQ-025 SHALL keep o_overrun set until i_clr or i_rst.
REQ-026 SHALL treat i_data as unsigned; max compare unsigned.

Reset
REQ-027 SHALL on i_rst high, asynchronously: o_avg=0, o_max=0, o_avg_valid=0, o_sample_cnt=0, o_overrun=0, acc=0, run_max=0, FSM EMPTY.
REQ-028 SHALL on i_rst mid-block discard partial block; first strobe after release counts as sample 0.
REQ-029 SHALL leave reset release synchronous handling to top level; block samples inputs from first rising edge after i_rst low.

Verification
REQ-030 SHALL test: words 100..107 strobed every cycle, i_avg_ready=1 -> o_avg=103, o_max=107, o_avg_valid one cycle after 8th strobe.
REQ-031 SHALL test: 8 words of 16'hFFFF -> o_avg=16'hFFFF, no wrap; then 8 words of 0 -> o_avg=0, o_max=0.
REQ-032 SHALL test: i_avg_ready=0 across two full blocks (avgs 10 then 20) -> o_avg stays 10, o_overrun=1; i_avg_ready pulse -> o_avg_valid=0; o_overrun stays 1 until i_clr.
REQ-033 SHALL test: PENDING with 2nd block's last strobe and i_avg_ready same cycle -> o_avg_valid stays 1, o_avg updates to new value, o_overrun=0.
REQ-034 SHALL test: 5 strobes then i_rst (or i_clr coincident with a strobe) -> o_sample_cnt=0; next 8 words 1..8 -> o_avg=4, o_max=8.
REQ-035 SHALL test: strobes spaced by random 0-20 idle cycles -> results match strobed-every-cycle reference model.
